dwc_rsp_fifo: RTL and testbench

//  Response FIFO between co-processor response bus and the 128->32 response width converter.
//  - Buffers full-width response beats; presents show-ahead head entry on the fifo_rsp_* interface.
//  - Decouples co-processor from the converter's multi-cycle unpack/send sequence.
//  - Provides occupancy and almost-full for upstream flow control.

---
 rtl/dwc_rsp_fifo.sv | 92 +++++++++
 tb/tb_dwc_rsp_fifo.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dwc_rsp_fifo.sv
// Show-ahead response FIFO feeding the 128->32 response width converter.
// Optional synchronous flush port is enabled by defining DWC_RSP_FIFO_FLUSH_EN.
module dwc_rsp_fifo #(
  parameter int DATA_WIDTH        = 128,
  parameter int DEPTH             = 4,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 1,
  parameter int CNT_W             = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cp_rsp_valid,
  output logic                  cp_rsp_ready,
  input  logic [DATA_WIDTH-1:0] cp_rsp_rdata,
  output logic                  fifo_rsp_valid,
  input  logic                  fifo_rsp_ready,
  output logic [DATA_WIDTH-1:0] fifo_rsp_rdata,
  output logic [CNT_W-1:0]      count,
  output logic                  almost_full
`ifdef DWC_RSP_FIFO_FLUSH_EN
 ,input  logic                  flush
`endif
);

  localparam logic [CNT_W-1:0] AF_LVL = CNT_W'(ALMOST_FULL_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0]      wr_ptr, rd_ptr, count_nxt;
  logic [CNT_W-2:0]      wr_idx, rd_idx;
  logic                  empty, full, push, pop;

  assign wr_idx = wr_ptr[CNT_W-2:0];
  assign rd_idx = rd_ptr[CNT_W-2:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_idx == rd_idx) && (wr_ptr[CNT_W-1] != rd_ptr[CNT_W-1]);

  // Ready is a function of registered pointers only, so a pop never frees a slot same-cycle.
  assign cp_rsp_ready   = !full;
  assign fifo_rsp_valid = !empty;
  assign fifo_rsp_rdata = mem[rd_idx];

  always_comb begin
    push = cp_rsp_valid && !full;
    pop  = fifo_rsp_ready && !empty;
`ifdef DWC_RSP_FIFO_FLUSH_EN
    if (flush) begin
      push = 1'b0;
      pop  = 1'b0;
    end
`endif
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CNT_W'(1);
    else if (pop && !push)
      count_nxt = count - CNT_W'(1);
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_idx] <= cp_rsp_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
`ifdef DWC_RSP_FIFO_FLUSH_EN
      if (flush) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        count       <= '0;
        almost_full <= 1'b0;
      end else
`endif
      begin
        if (push)
          wr_ptr <= wr_ptr + CNT_W'(1);
        if (pop)
          rd_ptr <= rd_ptr + CNT_W'(1);
        count       <= count_nxt;
        almost_full <= (count_nxt >= AF_LVL);
      end
    end
  end

endmodule

// File: tb/tb_dwc_rsp_fifo.sv
// Self-checking bench for dwc_rsp_fifo: vector table plus scoreboard, with reset,
// converter-style consumption and (when DWC_RSP_FIFO_FLUSH_EN is defined) flush sequences.
module tb_dwc_rsp_fifo;

  localparam int DW    = 128;
  localparam int DEPTH = 4;
  localparam int AFL   = 3;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cp_rsp_valid;
  logic          cp_rsp_ready;
  logic [DW-1:0] cp_rsp_rdata;
  logic          fifo_rsp_valid;
  logic          fifo_rsp_ready;
  logic [DW-1:0] fifo_rsp_rdata;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          flush;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model_q[$];
  logic [31:0]   exp_w[$];

  dwc_rsp_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .ALMOST_FULL_LEVEL(AFL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cp_rsp_valid(cp_rsp_valid),
    .cp_rsp_ready(cp_rsp_ready),
    .cp_rsp_rdata(cp_rsp_rdata),
    .fifo_rsp_valid(fifo_rsp_valid),
    .fifo_rsp_ready(fifo_rsp_ready),
    .fifo_rsp_rdata(fifo_rsp_rdata),
    .count(count),
    .almost_full(almost_full)
`ifdef DWC_RSP_FIFO_FLUSH_EN
   ,.flush(flush)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          r;
    logic          ev;
    logic          er;
    logic [CW-1:0] ec;
    logic          eaf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [DW-1:0] d, input logic r,
                              input logic ev, input logic er, input logic [CW-1:0] ec,
                              input logic eaf);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.ev = ev; t.er = er; t.ec = ec; t.eaf = eaf;
    return t;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic ev, input logic er,
                          input logic [CW-1:0] ec, input logic eaf);
    chk({tag, ".valid"}, DW'(fifo_rsp_valid), DW'(ev));
    chk({tag, ".ready"}, DW'(cp_rsp_ready), DW'(er));
    chk({tag, ".count"}, DW'(count), DW'(ec));
    chk({tag, ".af"}, DW'(almost_full), DW'(eaf));
  endtask

  // One clock: check against model at negedge, then advance model past the posedge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    logic do_push, do_pop;
    cp_rsp_valid   = v;
    cp_rsp_rdata   = d;
    fifo_rsp_ready = r;
    flush          = f;
    @(negedge clk);
    chk("sb.valid", DW'(fifo_rsp_valid), DW'(model_q.size() != 0));
    chk("sb.ready", DW'(cp_rsp_ready), DW'(model_q.size() < DEPTH));
    chk("sb.count", DW'(count), DW'(model_q.size()));
    chk("sb.af", DW'(almost_full), DW'(model_q.size() >= AFL));
    if (model_q.size() != 0)
      chk("sb.head", fifo_rsp_rdata, model_q[0]);
    do_push = v && (model_q.size() < DEPTH);
    do_pop  = r && (model_q.size() != 0);
    @(posedge clk);
    #1;
    if (f) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] beat;
    logic [31:0]   word;
    bit            seen;

    // Table: inputs for one cycle, outputs expected just after that edge.
    tbl.push_back(mk(1, DW'(1), 0, 1, 1, 3'd1, 0));
    tbl.push_back(mk(1, DW'(2), 0, 1, 1, 3'd2, 0));
    tbl.push_back(mk(0, DW'(0), 0, 1, 1, 3'd2, 0));
    tbl.push_back(mk(1, DW'(3), 0, 1, 1, 3'd3, 1));
    tbl.push_back(mk(1, DW'(4), 0, 1, 0, 3'd4, 1));
    tbl.push_back(mk(1, DW'(5), 0, 1, 0, 3'd4, 1));
    tbl.push_back(mk(1, DW'(5), 1, 1, 1, 3'd3, 1));
    tbl.push_back(mk(1, DW'(5), 0, 1, 0, 3'd4, 1));
    tbl.push_back(mk(0, DW'(0), 1, 1, 1, 3'd3, 1));
    tbl.push_back(mk(0, DW'(0), 1, 1, 1, 3'd2, 0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1, DW'(6 + i), 1, 1, 1, 3'd2, 0));
    tbl.push_back(mk(0, DW'(0), 1, 1, 1, 3'd1, 0));
    tbl.push_back(mk(0, DW'(0), 1, 0, 1, 3'd0, 0));
    tbl.push_back(mk(0, DW'(0), 1, 0, 1, 3'd0, 0));

    rst = 1'b1; cp_rsp_valid = 1'b0; cp_rsp_rdata = '0; fifo_rsp_ready = 1'b0; flush = 1'b0;
    #12;
    chk_outs("reset", 0, 1, 3'd0, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0);
      chk_outs($sformatf("vec%0d", i), tbl[i].ev, tbl[i].er, tbl[i].ec, tbl[i].eaf);
      if (i == 2)
        chk("held_head", fifo_rsp_rdata, DW'(1));
    end

    // Converter-style consumer: head held over four word slots, popped once per beat.
    for (int b = 0; b < 3; b++) begin
      for (int w = 0; w < 4; w++) begin
        beat[32*w +: 32] = 32'hC0DE_0000 + 32'(b * 4 + w);
        exp_w.push_back(32'hC0DE_0000 + 32'(b * 4 + w));
      end
      cycle(1, beat, 0, 0);
    end
    for (int b = 0; b < 3; b++) begin
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
        if (fifo_rsp_valid) seen = 1'b1;
        else cycle(0, '0, 0, 0);
      end
      chk("conv.wait_valid", DW'(seen), DW'(1));
      for (int w = 0; w < 4; w++) begin
        word = fifo_rsp_rdata[32*w +: 32];
        chk("conv.word", DW'(word), DW'(exp_w.pop_front()));
        cycle(0, '0, (w == 3), 0);
      end
    end
    chk_outs("conv.drained", 0, 1, 3'd0, 0);

    // Asynchronous reset at count=3 with a push pending.
    for (int i = 0; i < 3; i++)
      cycle(1, DW'(32'h100 + i), 0, 0);
    chk_outs("prerst", 1, 1, 3'd3, 1);
    cp_rsp_valid = 1'b1; cp_rsp_rdata = DW'(32'hAA); fifo_rsp_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_outs("async_rst", 0, 1, 3'd0, 0);
    @(posedge clk);
    #1;
    cp_rsp_valid = 1'b0;
    rst = 1'b0;
    model_q.delete();
    cycle(0, '0, 0, 0);
    chk_outs("post_rst", 0, 1, 3'd0, 0);

`ifdef DWC_RSP_FIFO_FLUSH_EN
    for (int i = 0; i < 3; i++)
      cycle(1, DW'(32'h200 + i), 0, 0);
    cycle(1, DW'(32'hBB), 0, 1);
    chk_outs("flush", 0, 1, 3'd0, 0);
    cycle(0, '0, 0, 0);
    chk_outs("post_flush", 0, 1, 3'd0, 0);
    cycle(1, DW'(32'hCC), 0, 0);
    chk_outs("flush_refill", 1, 1, 3'd1, 0);
    chk("flush_refill.head", fifo_rsp_rdata, DW'(32'hCC));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
